// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// State codes are fixed so software and debug tooling can decode them.
package imem_loader_pkg;

  localparam int ISIZE = 32;

  typedef enum logic [2:0] {
    LOADER_IDLE = 3'd0,
    LOADER_LEN  = 3'd1,
    LOADER_DATA = 3'd2,
    LOADER_CSUM = 3'd3,
    LOADER_DONE = 3'd4,
    LOADER_ERR  = 3'd5
  } loader_state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles four accepted bytes, little-endian, into one word.
// word_valid is combinational on the 4th byte so the FSM can act in the same cycle.
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter int W = ISIZE
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_byte_valid,
  input  logic [7:0]   i_byte,
  output logic         o_word_valid,
  output logic [W-1:0] o_word
);

  logic [1:0]   r_cnt;
  logic [W-1:0] r_shift;
  logic [W-1:0] w_next;

  // New bytes enter at the top so the first byte ends up in bits [7:0].
  assign w_next = {i_byte, r_shift[W-1:8]};

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt   <= 2'd0;
      r_shift <= '0;
    end else if (i_byte_valid) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= w_next;
    end
  end

  assign o_word_valid = i_byte_valid && !i_clear && (r_cnt == 2'd3);
  assign o_word       = w_next;

endmodule

// File: rtl/imem_loader.sv
// Streams a length/payload/checksum byte sequence into instruction memory
// and keeps the core in reset until a load completes with a good checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int               ISIZE     = imem_loader_pkg::ISIZE,
  parameter int               DEPTH     = 256,
  parameter logic [ISIZE-1:0] BASE_ADDR = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [7:0]       i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_imem_wen,
  output logic [ISIZE-1:0] o_imem_waddr,
  output logic [ISIZE-1:0] o_imem_wdata,
  output logic             o_hold_core,
  output logic             o_done,
  output logic             o_err
);

  loader_state_e    r_state, w_next_state;
  logic [ISIZE-1:0] r_len;
  logic [ISIZE-1:0] r_idx;
  logic [7:0]       r_csum;
  logic             r_wen;
  logic [ISIZE-1:0] r_waddr;
  logic [ISIZE-1:0] r_wdata;

  logic             w_accept;
  logic             w_pack_valid;
  logic             w_clear;
  logic             w_word_valid;
  logic [ISIZE-1:0] w_word;

  assign w_accept     = i_in_valid && o_in_ready;
  assign w_pack_valid = w_accept && (r_state == LOADER_LEN || r_state == LOADER_DATA);

  imem_word_packer #(.W(ISIZE)) u_packer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (w_clear),
    .i_byte_valid (w_pack_valid),
    .i_byte       (i_in_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= LOADER_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    o_in_ready   = 1'b0;
    case (r_state)
      LOADER_IDLE, LOADER_DONE, LOADER_ERR: begin
        if (i_start) begin
          w_next_state = LOADER_LEN;
          w_clear      = 1'b1;
        end
      end
      LOADER_LEN: begin
        o_in_ready = 1'b1;
        if (w_word_valid) begin
          if (w_word == '0 || w_word > ISIZE'(DEPTH)) w_next_state = LOADER_ERR;
          else                                        w_next_state = LOADER_DATA;
        end
      end
      LOADER_DATA: begin
        o_in_ready = 1'b1;
        if (w_word_valid && (r_idx == r_len - 1'b1)) w_next_state = LOADER_CSUM;
      end
      LOADER_CSUM: begin
        o_in_ready = 1'b1;
        if (w_accept) w_next_state = (i_in_data == r_csum) ? LOADER_DONE : LOADER_ERR;
      end
      default: w_next_state = LOADER_IDLE;
    endcase
  end

  // Write port registers: the strobe lands one cycle after the 4th byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len   <= '0;
      r_idx   <= '0;
      r_csum  <= 8'd0;
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wen <= 1'b0;
      if (w_clear) begin
        r_len  <= '0;
        r_idx  <= '0;
        r_csum <= 8'd0;
      end
      if (r_state == LOADER_LEN && w_word_valid) begin
        r_len <= w_word;
        r_idx <= '0;
      end
      if (r_state == LOADER_DATA && w_accept) r_csum <= r_csum ^ i_in_data;
      if (r_state == LOADER_DATA && w_word_valid) begin
        r_wen   <= 1'b1;
        r_waddr <= BASE_ADDR + r_idx;
        r_wdata <= w_word;
        r_idx   <= r_idx + 1'b1;
      end
    end
  end

  assign o_imem_wen   = r_wen;
  assign o_imem_waddr = r_waddr;
  assign o_imem_wdata = r_wdata;
  assign o_hold_core  = (r_state != LOADER_DONE);
  assign o_done       = (r_state == LOADER_DONE);
  assign o_err        = (r_state == LOADER_ERR);

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the processor's instruction fetch path.
- Receives a byte stream (length header, payload words, checksum) and writes 32-bit words into instruction memory at word addresses BASE_ADDR, BASE_ADDR+1, …
- Holds the core in reset until a load completes with a valid checksum.
- Sits between a host byte source (UART/debug bridge) and the instruction memory write port.

Parameters:
- ISIZE, 32, instruction word width; also the address width (`ISIZE from define.v).
- DEPTH, 256, maximum number of words the instruction memory accepts.
- BASE_ADDR, 0, first word address written; addresses are word-indexed, PC steps by 1.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_data  in  8  payload byte.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  loader accepts a byte; transfer occurs when in_valid && in_ready.
- imem_wen  out  1  instruction memory write strobe, one cycle per word.
- imem_waddr  out  ISIZE  word address for the write.
- imem_wdata  out  ISIZE  instruction word for the write.
- hold_core  out  1  high keeps the processor in reset.
- done  out  1  load finished with a good checksum.
- err  out  1  load rejected.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - in_ready=0, imem_wen=0, imem_waddr=0, imem_wdata=0.
  - hold_core=1, done=0, err=0.
  - Byte counters, word index, length and checksum all cleared.
  - The same applies to a reset mid-load: any partially assembled word is discarded and not written.
- States: IDLE, LEN, DATA, CSUM, DONE, ERR (encodings in define.v).
- IDLE:
  - in_ready=0; bytes are ignored.
  - start moves to LEN, clears the counters and checksum.
- LEN:
  - in_ready=1; takes 4 bytes, little-endian, into len (ISIZE bits).
  - On the 4th byte: if len==0 or len>DEPTH, go to ERR; otherwise go to DATA with idx=0.
- DATA:
  - in_ready=1; takes bytes little-endian into the word assembler.
  - Every accepted byte is XORed into csum.
  - A 4th byte accepted at cycle k produces imem_wen=1 at cycle k+1 with imem_waddr=BASE_ADDR+idx and the assembled word; idx then increments.
  - When the word with idx==len-1 completes, go to CSUM. That last write strobe lands in the first CSUM cycle.
- CSUM:
  - in_ready=1; takes 1 byte.
  - byte==csum: go to DONE.
  - Mismatch: go to ERR. Words already written are not undone.
- DONE: hold_core=0, done=1, in_ready=0.
- ERR: err=1, hold_core=1, in_ready=0.
- start in DONE or ERR:
  - Next cycle: done=0, err=0, hold_core=1, state=LEN.
  - start in LEN, DATA or CSUM is ignored.
- imem_wen is never high for more than one consecutive cycle per word. imem_waddr and imem_wdata hold their last values when imem_wen=0.
- Gaps in in_valid of any length stall progress without side effects. There is no timeout.
- start and in_valid in the same IDLE cycle: the byte is not consumed (in_ready=0 in IDLE).
- Throughput: 1 byte per cycle. Latency from the last checksum byte to done=1 is 1 cycle.

Decomposition:
- define.v:
  - Add LOADER_IDLE..LOADER_ERR state codes.
  - Reuse `ISIZE.
- Sub-module imem_word_packer:
  - Byte counter (2 bits) and 32-bit shift/assemble register.
  - Outputs word_valid for one cycle and the word.
  - Clear input driven by the FSM.
  - Reused for both the LEN field and DATA words.
- The FSM, index counter, checksum and write-port registers live in imem_loader.

Test Plan:
- Good 2-word load:
  - Stimulus: start, then 02 00 00 00 | 13 00 00 00 | 33 05 B5 00 | 90.
  - Response: writes addr0=0x00000013 and addr1=0x00B50533, one wen pulse each; then done=1, hold_core=0, err=0.
- Same stream with checksum byte 91: both writes occur, then err=1, hold_core=1, done=0.
- Length out of range:
  - 00 00 00 00 gives ERR after the 4th byte with zero writes.
  - 01 01 00 00 (257 > DEPTH) gives ERR with zero writes.
- Throttled input: the scenario-1 stream with random 0–5 cycle in_valid gaps gives identical writes and done.
- Bytes with in_valid=1 while in IDLE (no start) are not accepted (in_ready=0) and produce no wen.
- Reset and reload:
  - rst asserted after 6 DATA bytes: no further wen, hold_core=1, state IDLE.
  - A fresh scenario-1 load afterwards succeeds.
  - start in DONE raises hold_core and clears done the next cycle.
